// File: rtl/ellipse_scan_controller_pkg.sv
// Shared widths, renderer latency and scan state encoding for the ellipse renderer controllers.
package ellipse_scan_controller_pkg;

    localparam int X_W_DEF      = 11;
    localparam int Y_W_DEF      = 12;
    localparam int COL_W_DEF    = 8;
    localparam int PIPE_LAT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } scan_state_e;

    // Width of a counter that must hold the value n (never narrower than one bit).
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ellipse_scan_controller_if.sv
// Control/configuration inputs and renderer-facing outputs of the ellipse scan controller.
interface ellipse_scan_controller_if
    import ellipse_scan_controller_pkg::*;
#(
    parameter int X_W   = X_W_DEF,
    parameter int Y_W   = Y_W_DEF,
    parameter int COL_W = COL_W_DEF
) ();

    logic                    start;
    logic                    abort;
    logic                    hold;
    logic [X_W-2:0]          last_x;
    logic [Y_W-2:0]          last_y;
    logic [COL_W-1:0]        base_r;
    logic [COL_W-1:0]        base_g;
    logic [COL_W-1:0]        base_b;

    logic signed [X_W-1:0]   x;
    logic signed [Y_W-1:0]   y;
    logic [COL_W-1:0]        r;
    logic [COL_W-1:0]        g;
    logic [COL_W-1:0]        b;
    logic                    pix_valid;
    logic                    out_valid;
    logic                    busy;
    logic                    frame_done;

    modport master (
        input  start, abort, hold, last_x, last_y, base_r, base_g, base_b,
        output x, y, r, g, b, pix_valid, out_valid, busy, frame_done
    );

    modport slave (
        output start, abort, hold, last_x, last_y, base_r, base_g, base_b,
        input  x, y, r, g, b, pix_valid, out_valid, busy, frame_done
    );

endinterface

// File: rtl/valid_delay_line.sv
// DEPTH-stage 1-bit shift register with synchronous flush; tracks which renderer outputs are real.
module valid_delay_line #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] stage_q;
    logic [DEPTH-1:0] stage_d;

    always_comb begin
        // NOTE: stage_d gets a default before any branch so no latch can be inferred.
        stage_d = '0;
        if (!flush) begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/ellipse_scan_controller.sv
// Frame sequencer for ellipse_renderer: raster scan (x outer, y inner), hold/abort, pipeline drain tracking.
module ellipse_scan_controller
    import ellipse_scan_controller_pkg::*;
#(
    parameter int X_W      = X_W_DEF,
    parameter int Y_W      = Y_W_DEF,
    parameter int COL_W    = COL_W_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    ellipse_scan_controller_if.master bus
);

    localparam int CX_W  = X_W - 1;
    localparam int CY_W  = Y_W - 1;
    localparam int CNT_W = cnt_width(PIPE_LAT);

    scan_state_e           state_q, state_d;
    logic [CX_W-1:0]       cx_q, cx_d;
    logic [CY_W-1:0]       cy_q, cy_d;
    logic [CX_W-1:0]       last_x_q, last_x_d;
    logic [CY_W-1:0]       last_y_q, last_y_d;
    logic signed [X_W-1:0] x_q, x_d;
    logic signed [Y_W-1:0] y_q, y_d;
    logic [COL_W-1:0]      r_q, r_d;
    logic [COL_W-1:0]      g_q, g_d;
    logic [COL_W-1:0]      b_q, b_d;
    logic                  pix_valid_q, pix_valid_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;
    logic [CNT_W-1:0]      drain_cnt_q, drain_cnt_d;
    logic                  abort_act;

    // Abort only matters while a frame is in flight; it also flushes the valid pipeline.
    assign abort_act = bus.abort && (state_q != ST_IDLE);

    always_comb begin
        state_d      = state_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        last_x_d     = last_x_q;
        last_y_d     = last_y_q;
        x_d          = x_q;
        y_d          = y_q;
        r_d          = r_q;
        g_d          = g_q;
        b_d          = b_q;
        pix_valid_d  = 1'b0;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        drain_cnt_d  = drain_cnt_q;

        if (abort_act) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            x_d     = '0;
            y_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state_d  = ST_SCAN;
                        busy_d   = 1'b1;
                        last_x_d = bus.last_x;
                        last_y_d = bus.last_y;
                        r_d      = bus.base_r;
                        g_d      = bus.base_g;
                        b_d      = bus.base_b;
                        cx_d     = '0;
                        cy_d     = '0;
                        x_d      = '0;
                        y_d      = '0;
                    end
                end

                ST_SCAN: begin
                    if (!bus.hold) begin
                        x_d         = $signed({1'b0, cx_q});
                        y_d         = $signed({1'b0, cy_q});
                        pix_valid_d = 1'b1;
                        if (cy_q == last_y_q) begin
                            cy_d = '0;
                            if (cx_q == last_x_q) begin
                                state_d     = ST_DRAIN;
                                drain_cnt_d = '0;
                            end else begin
                                cx_d = cx_q + CX_W'(1);
                            end
                        end else begin
                            cy_d = cy_q + CY_W'(1);
                        end
                    end
                end

                ST_DRAIN: begin
                    // Final out_valid lands PIPE_LAT cycles after the last pixel; done follows one cycle later.
                    if (drain_cnt_q == CNT_W'(PIPE_LAT)) begin
                        state_d      = ST_IDLE;
                        busy_d       = 1'b0;
                        frame_done_d = 1'b1;
                    end else begin
                        drain_cnt_d = drain_cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q      <= ST_IDLE;
            cx_q         <= '0;
            cy_q         <= '0;
            last_x_q     <= '0;
            last_y_q     <= '0;
            x_q          <= '0;
            y_q          <= '0;
            r_q          <= '0;
            g_q          <= '0;
            b_q          <= '0;
            pix_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            drain_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            last_x_q     <= last_x_d;
            last_y_q     <= last_y_d;
            x_q          <= x_d;
            y_q          <= y_d;
            r_q          <= r_d;
            g_q          <= g_d;
            b_q          <= b_d;
            pix_valid_q  <= pix_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            drain_cnt_q  <= drain_cnt_d;
        end
    end

    valid_delay_line #(
        .DEPTH (PIPE_LAT)
    ) u_valid_delay (
        .clk   (clk),
        .rst   (rst),
        .flush (abort_act),
        .din   (pix_valid_q),
        .dout  (bus.out_valid)
    );

    assign bus.x          = x_q;
    assign bus.y          = y_q;
    assign bus.r          = r_q;
    assign bus.g          = g_q;
    assign bus.b          = b_q;
    assign bus.pix_valid  = pix_valid_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;

endmodule
